// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the fetch program counter and requests instructions over a
// variable-latency req/ack interface. Returned instructions are buffered together
// with their PC in a small FIFO that decode drains through valid/ready. A Redirect
// loads NextPC, flushes the FIFO and squashes any fetch that is still in flight.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INSTR_W  = 32,
  parameter int          DEPTH    = 2
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [63:0]        NextPC,
  input  logic               Redirect,
  output logic               IMemReq,
  output logic [63:0]        IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [63:0]        InstrPC,
  output logic               MisalignErr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [63:0] RESET_ADDR   = {RESET_PC[63:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_SQUASH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [63:0] fetch_pc, fetch_pc_next;
  logic [63:0] squash_addr, squash_addr_next;
  logic [63:0] addr_next;
  logic        req_next;
  logic        misalign_next;

  logic [63:0]        fifo_pc    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_after_pop;
  logic               pop, push, flush;

  assign InstrValid = (count != {CNT_W{1'b0}});
  assign Instr      = fifo_instr[rd_ptr];
  assign InstrPC    = fifo_pc[rd_ptr];

  // Next-state, fetch PC and FIFO control decode; the pop is applied before any credit test.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    squash_addr_next = squash_addr;
    push             = 1'b0;
    pop              = InstrValid && InstrReady;
    flush            = Redirect;
    count_after_pop  = count - (pop ? ONE_C : {CNT_W{1'b0}});

    case (state)
      S_IDLE: begin
        if (Redirect) begin
          // Flush empties the FIFO, so a request can always start.
          fetch_pc_next = NextPC;
          state_next    = S_REQ;
        end else if (count_after_pop < DEPTH_C) begin
          state_next = S_REQ;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (IMemAck && !Redirect) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 64'd4;
          if ((count_after_pop + ONE_C) < DEPTH_C) begin
            state_next = S_REQ;
          end else begin
            state_next = S_IDLE;
          end
        end else if (IMemAck && Redirect) begin
          // The returning data belongs to the old path and is dropped.
          fetch_pc_next = NextPC;
          state_next    = S_REQ;
        end else if (Redirect) begin
          // The old request must still complete on the bus with its own address.
          fetch_pc_next    = NextPC;
          squash_addr_next = IMemAddr;
          state_next       = S_SQUASH;
        end else begin
          state_next = S_REQ;
        end
      end
      S_SQUASH: begin
        if (Redirect) begin
          fetch_pc_next = NextPC;
        end else begin
          fetch_pc_next = fetch_pc;
        end
        if (IMemAck) begin
          state_next = S_REQ;
        end else begin
          state_next = S_SQUASH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    req_next = (state_next != S_IDLE);
    if (state_next == S_SQUASH) begin
      addr_next = squash_addr_next;
    end else begin
      addr_next = {fetch_pc_next[63:2], 2'b00};
    end
    misalign_next = MisalignErr || (Redirect && (NextPC[1:0] != 2'b00));
  end

  // State, fetch PC and registered memory-interface outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      squash_addr <= RESET_ADDR;
      IMemReq     <= 1'b0;
      IMemAddr    <= RESET_ADDR;
      MisalignErr <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      squash_addr <= squash_addr_next;
      IMemReq     <= req_next;
      IMemAddr    <= addr_next;
      MisalignErr <= misalign_next;
    end
  end

  // FIFO pointers and occupancy; a flush takes effect after this cycle's pop.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      count <= count_after_pop + (push ? ONE_C : {CNT_W{1'b0}});
    end
  end

  // FIFO storage: instruction tagged with the PC it was fetched from.
  always_ff @(posedge CLK) begin
    if (push && !Reset) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= IMemData;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a latency-programmable memory model answers requests,
// a scoreboard records every instruction that should reach decode and checks each
// pop, and directed sequences cover redirect, squash, wrap, misalignment and reset.
module tb_fetch_pc_unit;

  localparam logic [63:0] RPC = 64'h100;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] NextPC = 64'h0;
  logic        Redirect = 1'b0;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic        InstrValid;
  logic        InstrReady = 1'b1;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        MisalignErr;

  fetch_pc_unit #(.RESET_PC(RPC), .INSTR_W(32), .DEPTH(2)) dut (
    .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Redirect(Redirect),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC),
    .MisalignErr(MisalignErr)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t q[$];

  int total = 0;
  int bad = 0;

  // reference model / memory model state
  logic [63:0] m_pc = RPC;
  logic [63:0] m_sq_addr = 64'h0;
  bit m_sq = 1'b0;
  bit m_mis = 1'b0;
  int lat = 1;
  int cnt = 0;
  bit mem_ack = 1'b0;
  bit force_ack = 1'b0;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  // one clock: drive ack, advance, update the model, check, and plan the next ack
  task automatic step();
    bit p_reset, p_red, p_ack, p_ackin, p_req, p_valid, p_ready;
    logic [63:0] p_next, p_addr, p_ipc;
    logic [31:0] p_data, p_instr;
    IMemAck  = mem_ack | force_ack;
    IMemData = mem_data(IMemAddr);
    p_reset = Reset; p_red = Redirect; p_ack = mem_ack; p_ackin = IMemAck;
    p_req = IMemReq; p_valid = InstrValid; p_ready = InstrReady;
    p_next = NextPC; p_addr = IMemAddr; p_ipc = InstrPC;
    p_data = IMemData; p_instr = Instr;
    @(posedge CLK);
    #1;
    if (p_reset) begin
      q.delete();
      m_pc = RPC; m_sq = 1'b0; m_mis = 1'b0;
    end else begin
      if (p_valid && p_ready) begin
        if (q.size() == 0) begin
          chk1("pop_unexpected", 1'b1, 1'b0);
        end else begin
          ent_t e;
          e = q.pop_front();
          chk("pop_pc", p_ipc, e.pc);
          chk("pop_instr", {32'h0, p_instr}, {32'h0, e.instr});
        end
      end
      if (p_red) begin
        q.delete();
        m_pc = p_next;
        if (p_next[1:0] != 2'b00) m_mis = 1'b1;
        if (p_ack) m_sq = 1'b0;
        else if (p_req && !m_sq) begin
          m_sq = 1'b1;
          m_sq_addr = p_addr;
        end
      end else if (p_ack) begin
        if (m_sq) m_sq = 1'b0;
        else begin
          q.push_back('{m_pc, p_data});
          m_pc = m_pc + 64'd4;
        end
      end
      if (p_req && !p_ackin && IMemReq)
        chk("addr_stable", IMemAddr, p_addr);
    end
    chk1("valid", InstrValid, q.size() != 0);
    chk1("misalign", MisalignErr, m_mis);
    if (IMemReq)
      chk("addr", IMemAddr, m_sq ? m_sq_addr : {m_pc[63:2], 2'b00});
    if (IMemReq) begin
      if (cnt >= lat) begin mem_ack = 1'b1; cnt = 0; end
      else begin mem_ack = 1'b0; cnt++; end
    end else begin
      mem_ack = 1'b0; cnt = 0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Redirect = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // kind 0: IMemAddr==target with IMemReq, 1: InstrValid, 2: memory about to ack
  task automatic wait_for(input int kind, input logic [63:0] target, input string n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (kind == 0) hit = IMemReq && (IMemAddr == target);
      else if (kind == 1) hit = InstrValid;
      else hit = mem_ack;
      if (!hit) step();
    end
    chk1(n, hit, 1'b1);
  endtask

  typedef struct {
    bit rst; bit ready;
    bit exp_req; logic [63:0] exp_addr; bit exp_valid; logic [63:0] exp_pc;
  } vec_t;
  vec_t tv[8];

  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b0, 64'h100, 1'b0, 64'h0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 64'h100, 1'b0, 64'h0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 64'h100, 1'b0, 64'h0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 64'h104, 1'b1, 64'h100};
    tv[4] = '{1'b0, 1'b1, 1'b1, 64'h104, 1'b0, 64'h0};
    tv[5] = '{1'b0, 1'b1, 1'b1, 64'h108, 1'b1, 64'h104};
    tv[6] = '{1'b0, 1'b1, 1'b1, 64'h108, 1'b0, 64'h0};
    tv[7] = '{1'b0, 1'b1, 1'b1, 64'h10C, 1'b1, 64'h108};

    // Sequential fetch from reset, one wait cycle per request
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      Reset = tv[i].rst; InstrReady = tv[i].ready;
      step();
      chk1($sformatf("t1_req[%0d]", i), IMemReq, tv[i].exp_req);
      chk($sformatf("t1_addr[%0d]", i), IMemAddr, tv[i].exp_addr);
      chk1($sformatf("t1_valid[%0d]", i), InstrValid, tv[i].exp_valid);
      if (tv[i].exp_valid)
        chk($sformatf("t1_pc[%0d]", i), InstrPC, tv[i].exp_pc);
    end
    steps(10);

    // Backpressure: FIFO fills to DEPTH, fetch stops, then resumes at 108
    lat = 0; InstrReady = 1'b0;
    do_reset();
    steps(6);
    chk1("t2_req_stopped", IMemReq, 1'b0);
    chk1("t2_valid", InstrValid, 1'b1);
    chk("t2_head", InstrPC, 64'h100);
    InstrReady = 1'b1;
    step();
    chk1("t2_req_resume", IMemReq, 1'b1);
    chk("t2_addr_resume", IMemAddr, 64'h108);
    steps(10);

    // Redirect while a request is pending: old address held, data dropped
    lat = 3;
    do_reset();
    wait_for(0, 64'h108, "t3_reach_108");
    Redirect = 1'b1; NextPC = 64'h200;
    step();
    Redirect = 1'b0;
    chk1("t3_flushed", InstrValid, 1'b0);
    chk1("t3_req_held", IMemReq, 1'b1);
    chk("t3_addr_held", IMemAddr, 64'h108);
    wait_for(0, 64'h200, "t3_req_200");
    wait_for(1, 64'h0, "t3_valid");
    chk("t3_first_pc", InstrPC, 64'h200);
    steps(4);

    // Redirect in the same cycle as an ack
    lat = 1;
    do_reset();
    wait_for(2, 64'h0, "t4_ack");
    Redirect = 1'b1; NextPC = 64'h300;
    step();
    Redirect = 1'b0;
    chk1("t4_req", IMemReq, 1'b1);
    chk("t4_addr", IMemAddr, 64'h300);
    wait_for(1, 64'h0, "t4_valid");
    chk("t4_first_pc", InstrPC, 64'h300);
    steps(4);

    // PC wraps at 2^64, then a misaligned redirect
    wait_for(2, 64'h0, "t5_ack");
    Redirect = 1'b1; NextPC = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    Redirect = 1'b0;
    chk("t5_addr_top", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_for(2, 64'h0, "t5_ack_top");
    step();
    chk("t5_addr_wrap", IMemAddr, 64'h0);
    chk1("t5_mis_clear", MisalignErr, 1'b0);
    Redirect = 1'b1; NextPC = 64'h402;
    step();
    Redirect = 1'b0;
    wait_for(0, 64'h400, "t5_addr_400");
    chk1("t5_mis_set", MisalignErr, 1'b1);
    wait_for(1, 64'h0, "t5_valid");
    chk("t5_pc_verbatim", InstrPC, 64'h402);
    steps(8);
    chk1("t5_mis_sticky", MisalignErr, 1'b1);
    do_reset();
    chk1("t5_mis_reset", MisalignErr, 1'b0);

    // Reset with a request outstanding and FIFO occupied; late ack ignored
    lat = 0; InstrReady = 1'b0;
    do_reset();
    steps(6);
    lat = 5; InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    steps(2);
    chk1("t6_req_out", IMemReq, 1'b1);
    chk1("t6_valid_pre", InstrValid, 1'b1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk1("t6_req_off", IMemReq, 1'b0);
    chk1("t6_valid_off", InstrValid, 1'b0);
    chk("t6_addr_reset", IMemAddr, RPC);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk1("t6_late_ack_ignored", InstrValid, 1'b0);
    chk1("t6_req_restart", IMemReq, 1'b1);
    chk("t6_addr_restart", IMemAddr, RPC);
    lat = 1; InstrReady = 1'b1;
    wait_for(1, 64'h0, "t6_valid");
    chk("t6_first_pc", InstrPC, RPC);
    steps(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
